// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives ReadPC, buffers {instruction, pc} pairs in a prefetch FIFO, redirect flushes.
// Optional build macro FETCH_STATS_EN adds fetch_cnt / flush_cnt statistics outputs.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ReadPC,
  input  logic [31:0] Instruction,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          push;
  logic          pop;

  // Handshake: the head transfers on a cycle where inst_valid && inst_ready && !redirect;
  // a redirect cycle never consumes the head, it discards the whole FIFO instead.
  assign push = !redirect && !halt && (count != FULL);
  assign pop  = !redirect && inst_valid && inst_ready;

  assign ReadPC     = pc;
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? instr_mem[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr]    : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Full check uses the count at cycle start, so a same-cycle pop never unblocks a push.
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= Instruction;
      pc_mem[wr_ptr]    <= pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (push)     fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model of the fetch stream plus directed and random scenarios.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ReadPC;
  logic [31:0] Instruction;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int total  = 0;
  int passed = 0;

  // Reference model: the FIFO is simply a queue of PCs, instruction value is derived from the PC.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  logic [96:0] obs;
  assign obs = {inst_valid, inst_pc, inst_out, ReadPC};

  // Memory model: mem[i] = 32'h100 + i, combinational read.
  assign Instruction = 32'h100 + ReadPC;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .ReadPC      (ReadPC),
    .Instruction (Instruction),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  function automatic logic [96:0] exp_bundle();
    if (exp_q.size() != 0) return {1'b1, exp_q[0], 32'h100 + exp_q[0], m_pc};
    return {1'b0, 32'h0, 32'h0, m_pc};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_fetch = 32'h0;
    m_flush = 32'h0;
  endtask

  task automatic model_edge(input logic r, input logic [31:0] rpc, input logic h, input logic rdy);
    bit do_push;
    bit do_pop;
    if (r) begin
      exp_q.delete();
      m_pc = rpc;
      m_flush++;
    end else begin
      do_push = !h && (exp_q.size() < DEPTH);
      do_pop  = (exp_q.size() > 0) && rdy;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(m_pc);
        m_pc++;
        m_fetch++;
      end
    end
  endtask

  // Drive inputs away from the edge, clock once, advance the model, settle for sampling.
  task automatic cycle(input logic r, input logic [31:0] rpc, input logic h, input logic rdy);
    redirect    = r;
    redirect_pc = rpc;
    halt        = h;
    inst_ready  = rdy;
    @(posedge clk);
    model_edge(r, rpc, h, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    redirect = 1'b0; halt = 1'b0; inst_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (obs !== {1'b0, 32'h0, 32'h0, RESET_PC})
      $display("FAIL reset_state got=%h want=%h", obs, {1'b0, 32'h0, 32'h0, RESET_PC});
    else passed++;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, RESET_PC, 32'h100 + RESET_PC})
      $display("FAIL first_fetch got=%h want=%h", {inst_valid, inst_pc, inst_out}, {1'b1, RESET_PC, 32'h100 + RESET_PC});
    else passed++;
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (obs !== exp_bundle()) $display("FAIL stream_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      total++;
      if (obs !== exp_bundle()) $display("FAIL stall_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
    total++;
    if (ReadPC !== 32'd4) $display("FAIL stall_readpc got=%h want=%h", ReadPC, 32'd4);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (obs !== exp_bundle()) $display("FAIL drain_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (exp_q.size() != 3 || obs !== exp_bundle())
      $display("FAIL redir_setup got=%h want=%h", obs, exp_bundle());
    else passed++;
    cycle(1'b1, 32'h20, 1'b0, 1'b1);
    total++;
    if ({inst_valid, ReadPC} !== {1'b0, 32'h20})
      $display("FAIL redir_flush got=%h want=%h", {inst_valid, ReadPC}, {1'b0, 32'h20});
    else passed++;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h20, 32'h120})
      $display("FAIL redir_target got=%h want=%h", {inst_valid, inst_pc, inst_out}, {1'b1, 32'h20, 32'h120});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if (obs !== exp_bundle()) $display("FAIL redir_run_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
  endtask

  task automatic test_halt();
    logic [31:0] held;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    held = ReadPC;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      total++;
      if (obs !== exp_bundle() || ReadPC !== held)
        $display("FAIL halt_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
    total++;
    if (inst_valid !== 1'b0) $display("FAIL halt_empty got=%b want=0", inst_valid);
    else passed++;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    total++;
    if ({inst_valid, inst_pc} !== {1'b1, held})
      $display("FAIL halt_resume got=%h want=%h", {inst_valid, inst_pc}, {1'b1, held});
    else passed++;
  endtask

  task automatic test_wrap_and_async_reset();
    logic [31:0] want;
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    want = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      total++;
      if ({inst_valid, inst_pc, inst_out} !== {1'b1, want, 32'h100 + want})
        $display("FAIL wrap_%0d got=%h want=%h", i, {inst_valid, inst_pc, inst_out}, {1'b1, want, 32'h100 + want});
      else passed++;
      want++;
    end
    // Assert reset mid-cycle, well away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obs !== {1'b0, 32'h0, 32'h0, RESET_PC})
      $display("FAIL async_reset got=%h want=%h", obs, {1'b0, 32'h0, 32'h0, RESET_PC});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic        r;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 9) == 0);
      rpc = $urandom();
      cycle(r, rpc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1));
      total++;
      if (obs !== exp_bundle()) $display("FAIL random_%0d got=%h want=%h", i, obs, exp_bundle());
      else passed++;
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h40, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h80, 1'b0, 1'b1);
    total++;
    if ({fetch_cnt, flush_cnt} !== {32'd6, 32'd2})
      $display("FAIL stats_count got=%h want=%h", {fetch_cnt, flush_cnt}, {32'd6, 32'd2});
    else passed++;
    test_random();
    total++;
    if ({fetch_cnt, flush_cnt} !== {m_fetch, m_flush})
      $display("FAIL stats_random got=%h want=%h", {fetch_cnt, flush_cnt}, {m_fetch, m_flush});
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({fetch_cnt, flush_cnt} !== 64'h0)
      $display("FAIL stats_reset got=%h want=%h", {fetch_cnt, flush_cnt}, 64'h0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap_and_async_reset();
    test_random();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
